// File: rtl/if_id_hazard_stage_pkg.sv
// if_id_hazard_stage_pkg: FSM state encodings, NOP constant and instruction field positions for the IF/ID stage
package if_id_hazard_stage_pkg;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
  localparam logic [31:0] NOP = 32'h0;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
endpackage

// File: rtl/if_id_hazard_stage_hazard_detect_unit.sv
// hazard_detect_unit: combinational load-use compare between the ID/EX load destination and the decode-stage source fields
// Ports:
//   valid       in  decode-stage instruction is real
//   enable      in  detection allowed (low while the stage is already stalling)
//   mem_read    in  ID/EX holds a load
//   ex_rt       in  ID/EX load destination register
//   instruction in  instruction currently in decode
//   hazard      out load-use hazard present
module hazard_detect_unit
  import if_id_hazard_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      valid,
  input  logic                      enable,
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic [DATA_WIDTH-1:0]     instruction,
  output logic                      hazard
);
  logic rs_match, rt_match;
  assign rs_match = ex_rt == instruction[RS_MSB:RS_LSB];
  assign rt_match = ex_rt == instruction[RT_MSB:RT_LSB];
  // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = valid & enable & mem_read & (|ex_rt) & (rs_match | rt_match);
endmodule

// File: rtl/if_id_hazard_stage.sv
// if_id_hazard_stage: IF/ID pipeline register with load-use stall, bubble request and branch/jump flush
// Ports:
//   clk, reset (async, active-low)
//   instruction_in, pc_plus_4_in       fetched instruction and its PC+4
//   id_ex_mem_read_in, id_ex_rt_in     load info currently held in ID/EX
//   flush_in                           taken branch/jump resolved this cycle
//   instruction_out, pc_plus_4_out     IF/ID contents presented to decode
//   valid_out                          0 = squashed NOP
//   pc_write_out                       PC enable (0 = hold PC)
//   bubble_out                         ID/EX loads zero control this edge
//   stall_count_out, flush_count_out   saturating performance counters
// Configuration: define HAZARD_PERF_COUNTERS_EN to build the counters; otherwise they read 0.
module if_id_hazard_stage
  import if_id_hazard_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     instruction_in,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4_in,
  input  logic                      id_ex_mem_read_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rt_in,
  input  logic                      flush_in,
  output logic [DATA_WIDTH-1:0]     instruction_out,
  output logic [DATA_WIDTH-1:0]     pc_plus_4_out,
  output logic                      valid_out,
  output logic                      pc_write_out,
  output logic                      bubble_out,
  output logic [CNT_WIDTH-1:0]      stall_count_out,
  output logic [CNT_WIDTH-1:0]      flush_count_out
);
  state_t state, state_next;
  logic hazard;
  hazard_detect_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hdu (
    .valid       (valid_out),
    .enable      (state == RUN),
    .mem_read    (id_ex_mem_read_in),
    .ex_rt       (id_ex_rt_in),
    .instruction (instruction_out),
    .hazard      (hazard)
  );
  // A flush squashes the instruction that would have stalled, so it always wins.
  assign pc_write_out = ~hazard | flush_in;
  assign bubble_out   = hazard | flush_in;
  always_comb begin
    state_next = (hazard & ~flush_in) ? STALL : RUN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= RUN;
      instruction_out <= NOP;
      pc_plus_4_out   <= '0;
      valid_out       <= 1'b0;
    end else begin
      state <= state_next;
      if (flush_in) begin
        instruction_out <= NOP;
        pc_plus_4_out   <= pc_plus_4_in;
        valid_out       <= 1'b0;
      end else if (!hazard) begin
        instruction_out <= instruction_in;
        pc_plus_4_out   <= pc_plus_4_in;
        valid_out       <= 1'b1;
      end
    end
  end
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && !flush_in && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_in && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
  assign stall_count_out = stall_cnt;
  assign flush_count_out = flush_cnt;
`else
  assign stall_count_out = '0;
  assign flush_count_out = '0;
`endif
endmodule
